// File: rtl/icache_down_responder.sv
// Downstream responder for the icache miss interface: queues line reads and
// returns address-derived data beats after a fixed latency, tagged with entry_id.
module icache_down_responder #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned BEAT_WIDTH = 256,
    parameter int unsigned LINE_BYTES = 64,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         downstream_txreq_vld,
    output logic                         downstream_txreq_rdy,
    input  logic [ADDR_WIDTH-1:0]        downstream_txreq_pld,
    input  logic [ID_WIDTH-1:0]          downstream_txreq_entry_id,
    output logic                         downstream_rxdat_vld,
    input  logic                         downstream_rxdat_rdy,
    output logic [BEAT_WIDTH-1:0]        downstream_rxdat_pld,
    output logic [ID_WIDTH-1:0]          downstream_rxdat_txnid,
    output logic                         downstream_rxdat_last,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding
);

    localparam int unsigned BEATS  = LINE_BYTES * 8 / BEAT_WIDTH;
    localparam int unsigned WPB    = BEAT_WIDTH / 32;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned LAT_W  = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SEND
    } state_t;

    state_t                state_q, state_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;

    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [ID_WIDTH-1:0]   id_mem   [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic                  push, pop, last_beat;

    assign downstream_txreq_rdy = (count_q < CNT_W'(DEPTH)) && !rst;
    assign push                 = downstream_txreq_vld && downstream_txreq_rdy;
    assign last_beat            = (beat_q == BEAT_W'(BEATS - 1));
    assign pop                  = (state_q == SEND) && downstream_rxdat_rdy && last_beat;
    assign outstanding          = count_q;
    assign head_addr            = addr_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= downstream_txreq_pld & ~ADDR_WIDTH'(LINE_BYTES - 1);
            id_mem[wr_ptr_q]   <= downstream_txreq_entry_id;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lat_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
        end
    end

    // The IDLE cycle spent noticing a fresh request is part of the latency,
    // so that path loads one less than the back-to-back path out of SEND.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    if (LATENCY == 1) begin
                        state_d = SEND;
                    end else begin
                        state_d = WAIT;
                        lat_d   = LAT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (lat_q <= LAT_W'(1)) begin
                    state_d = SEND;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            SEND: begin
                if (downstream_rxdat_rdy) begin
                    if (last_beat) begin
                        beat_d = '0;
                        if ((count_q > CNT_W'(1)) || push) begin
                            state_d = WAIT;
                            lat_d   = LAT_W'(LATENCY);
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        downstream_rxdat_vld   = (state_q == SEND);
        downstream_rxdat_last  = (state_q == SEND) && last_beat;
        downstream_rxdat_txnid = '0;
        downstream_rxdat_pld   = '0;
        if (state_q == SEND) begin
            downstream_rxdat_txnid = id_mem[rd_ptr_q];
            for (int unsigned k = 0; k < WPB; k++) begin
                downstream_rxdat_pld[32*k +: 32] = head_addr + 32'((32'(beat_q) * WPB + k) * 4);
            end
        end
    end

endmodule
